// File: rtl/conv_tile_engine.sv
// Sequential single-MAC convolution engine for one CNN tile.
// Walks (to,row,col) output pixels and streams each result over a valid/ready port.
module conv_tile_engine #(
  parameter int DW    = 8,
  parameter int TI    = 3,
  parameter int TO    = 4,
  parameter int IH    = 11,
  parameter int IW    = 11,
  parameter int K     = 3,
  parameter int S     = 1,
  parameter int ACC_W = 24,
  localparam int OH   = (IH - K) / S + 1,
  localparam int OW   = (IW - K) / S + 1,
  localparam int CHW  = (TO > 1) ? $clog2(TO) : 1,
  localparam int RW   = (OH > 1) ? $clog2(OH) : 1,
  localparam int CLW  = (OW > 1) ? $clog2(OW) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     relu_en,
  input  logic [TI*IH*IW*DW-1:0]   ifm_data,
  input  logic [TO*TI*K*K*DW-1:0]  wgt_data,
  output logic                     busy,
  output logic                     done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic [CHW-1:0]           out_ch,
  output logic [RW-1:0]            out_row,
  output logic [CLW-1:0]           out_col
);
  localparam int TIW = (TI > 1) ? $clog2(TI) : 1;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int XB  = $clog2(TI*IH*IW*DW);
  localparam int WB  = $clog2(TO*TI*K*K*DW);

  typedef enum logic [1:0] {IDLE, MAC, OUT, DONE} state_e;

  state_e                   state_q;
  logic [CHW-1:0]           to_q;
  logic [RW-1:0]            row_q;
  logic [CLW-1:0]           col_q;
  logic [TIW-1:0]           ti_q;
  logic [KW-1:0]            i_q, j_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     relu_q;
  logic                     busy_q, done_q, out_valid_q;
  logic [ACC_W-1:0]         out_data_q;
  logic [CHW-1:0]           out_ch_q;
  logic [RW-1:0]            out_row_q;
  logic [CLW-1:0]           out_col_q;

  logic [XB-1:0]            x_idx;
  logic [WB-1:0]            w_idx;
  logic signed [DW-1:0]     x_el, w_el;
  logic signed [2*DW-1:0]   prod;
  logic                     mac_last, pix_last;

  // Operands are fetched straight from the flat buses; callers keep them stable while busy.
  always_comb begin
    x_idx = XB'(((int'(ti_q)*IH + int'(row_q)*S + int'(i_q))*IW
                 + int'(col_q)*S + int'(j_q))*DW);
    w_idx = WB'((((int'(to_q)*TI + int'(ti_q))*K + int'(i_q))*K + int'(j_q))*DW);
    x_el  = ifm_data[x_idx +: DW];
    w_el  = wgt_data[w_idx +: DW];
    prod  = x_el * w_el;
    acc_d = acc_q + ACC_W'(prod);
  end

  assign mac_last = (ti_q == TIW'(TI-1)) && (i_q == KW'(K-1)) && (j_q == KW'(K-1));
  assign pix_last = (to_q == CHW'(TO-1)) && (row_q == RW'(OH-1)) && (col_q == CLW'(OW-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      to_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      ti_q        <= '0;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      relu_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          relu_q  <= relu_en;
          to_q    <= '0;
          row_q   <= '0;
          col_q   <= '0;
          ti_q    <= '0;
          i_q     <= '0;
          j_q     <= '0;
          acc_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= MAC;
        end
        MAC: begin
          acc_q <= acc_d;
          if (mac_last) begin
            out_data_q  <= (relu_q && acc_d[ACC_W-1]) ? '0 : acc_d;
            out_ch_q    <= to_q;
            out_row_q   <= row_q;
            out_col_q   <= col_q;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else if (j_q == KW'(K-1)) begin
            j_q <= '0;
            if (i_q == KW'(K-1)) begin
              i_q  <= '0;
              ti_q <= ti_q + 1'b1;
            end else begin
              i_q <= i_q + 1'b1;
            end
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          if (pix_last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            if (col_q == CLW'(OW-1)) begin
              col_q <= '0;
              if (row_q == RW'(OH-1)) begin
                row_q <= '0;
                to_q  <= to_q + 1'b1;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
            acc_q   <= '0;
            ti_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            state_q <= MAC;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
endmodule

// File: tb/tb_conv_tile_engine.sv
// Scoreboard bench for conv_tile_engine: default-size instance plus a stride-2 instance.
module tb_conv_tile_engine;
  localparam int DW = 8, TI = 3, TO = 4, IH = 11, IW = 11, K = 3, ACC_W = 24;
  localparam int OH = 9, OW = 9, N = TI*K*K, NPIX = TO*OH*OW;
  localparam int OH2 = 5, OW2 = 5;
  localparam int BOUND = NPIX*(N+1) + 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                     start, relu_en, out_ready, busy, done, out_valid;
  logic [TI*IH*IW*DW-1:0]   ifm;
  logic [TO*TI*K*K*DW-1:0]  wgt;
  logic [ACC_W-1:0]         out_data;
  logic [1:0]               out_ch;
  logic [3:0]               out_row, out_col;

  logic                     s_start, s_relu, s_ready, s_busy, s_done, s_valid;
  logic [TI*IH*IW*DW-1:0]   s_ifm;
  logic [TO*TI*K*K*DW-1:0]  s_wgt;
  logic [ACC_W-1:0]         s_data;
  logic [1:0]               s_ch;
  logic [2:0]               s_row, s_col;

  conv_tile_engine u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en),
    .ifm_data(ifm), .wgt_data(wgt), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_row(out_row), .out_col(out_col));

  conv_tile_engine #(.S(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .relu_en(s_relu),
    .ifm_data(s_ifm), .wgt_data(s_wgt), .busy(s_busy), .done(s_done),
    .out_valid(s_valid), .out_ready(s_ready), .out_data(s_data),
    .out_ch(s_ch), .out_row(s_row), .out_col(s_col));

  logic [63:0] q[$];
  logic [63:0] sq[$];
  int n_chk = 0, n_fail = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitors: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) check("unexpected_result", 64'({out_data, out_ch, out_row, out_col}), 64'hDEAD);
      else check("result", 64'({out_data, out_ch, out_row, out_col}), q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_valid && s_ready) begin
      if (sq.size() == 0) check("s2_unexpected", 64'({s_data, s_ch, s_row, s_col}), 64'hDEAD);
      else check("s2_result", 64'({s_data, s_ch, s_row, s_col}), sq.pop_front());
    end
  end

  task automatic set_all(input int xv, input int wv);
    for (int k = 0; k < TI*IH*IW; k++) ifm[k*DW +: DW] = DW'(xv);
    for (int k = 0; k < TO*TI*K*K; k++) wgt[k*DW +: DW] = DW'(wv);
  endtask

  task automatic push_tile(input logic [ACC_W-1:0] v);
    for (int t = 0; t < TO; t++)
      for (int r = 0; r < OH; r++)
        for (int c = 0; c < OW; c++)
          q.push_back(64'({v, 2'(t), 4'(r), 4'(c)}));
  endtask

  task automatic run_tile(input logic relu, input bit hold, input int bp, input logic [ACC_W-1:0] v);
    int k, fv, dn, dcnt, bpc, hs;
    push_tile(v);
    @(posedge clk); #1;
    start = 1'b1; relu_en = relu; out_ready = 1'b1;
    @(posedge clk); #1;
    relu_en = ~relu;
    if (!hold) start = 1'b0;
    check("busy_after_start", {busy, out_valid}, 2'b10);
    k = 0; fv = -1; dn = -1; dcnt = 0; bpc = 0; hs = -1;
    while (dn < 0 && k < BOUND) begin
      @(posedge clk); #1;
      k++;
      if (bpc > 0) begin
        check("bp_hold", 64'({out_valid, out_data, out_ch, out_row, out_col}), 64'({1'b1, v, 10'd0}));
        bpc--;
        if (bpc == 0) begin out_ready = 1'b1; hs = k + 1; end
      end
      if (out_valid && fv < 0) begin
        fv = k;
        if (bp > 0) begin out_ready = 1'b0; bpc = bp; end
      end
      if (hs > 0 && k == hs + N - 1) check("bp_gap", out_valid, 0);
      if (hs > 0 && k == hs + N) check("bp_next", out_valid, 1);
      if (done) begin dn = k; dcnt++; end
    end
    check("first_valid", fv, N);
    check("done_time", dn, NPIX*(N+1) + bp);
    check("busy_at_done", busy, 0);
    // start is still high through the DONE cycle when hold is set
    for (int w = 0; w < 4; w++) begin
      @(posedge clk); #1;
      if (w == 0) start = 1'b0;
      if (done) dcnt++;
    end
    check("done_once", dcnt, 1);
    check("idle_after", {busy, out_valid, done}, 3'b000);
    check("queue_empty", q.size(), 0);
  endtask

  initial begin
    int k, dn;
    start = 1'b0; relu_en = 1'b0; out_ready = 1'b1;
    s_start = 1'b0; s_relu = 1'b0; s_ready = 1'b1;
    ifm = '0; wgt = '0; s_ifm = '0; s_wgt = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'({busy, done, out_valid, out_data, out_ch, out_row, out_col}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", 64'({busy, done, out_valid, out_data}), 0);

    set_all(1, 1);
    run_tile(1'b0, 1'b0, 0, 24'd27);

    set_all(1, -1);
    run_tile(1'b0, 1'b0, 0, 24'hFFFFE5);
    run_tile(1'b1, 1'b1, 0, 24'd0);

    // Reset while accumulating pixel (1,4,4), i.e. flat pixel index 121.
    set_all(1, 1);
    push_tile(24'd27);
    @(posedge clk); #1;
    start = 1'b1; relu_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (121*(N+1) + 10) @(posedge clk);
    #1;
    check("pre_reset_popped", q.size(), NPIX - 121);
    check("pre_reset_busy", {busy, out_valid}, 2'b10);
    rst_n = 1'b0;
    q.delete();
    #1;
    check("reset_mid", 64'({busy, done, out_valid, out_data, out_ch, out_row, out_col}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_idle", 64'({busy, out_valid, out_data}), 0);

    run_tile(1'b0, 1'b0, 5, 24'd27);

    // Stride-2 instance: ifm(ti,r,c)=c, only the kernel centre of input channel 0 is set.
    for (int t = 0; t < TI; t++)
      for (int r = 0; r < IH; r++)
        for (int c = 0; c < IW; c++)
          s_ifm[((t*IH + r)*IW + c)*DW +: DW] = DW'(c);
    for (int o = 0; o < TO; o++) s_wgt[(((o*TI)*K + 1)*K + 1)*DW +: DW] = 8'd1;
    for (int o = 0; o < TO; o++)
      for (int r = 0; r < OH2; r++)
        for (int c = 0; c < OW2; c++)
          sq.push_back(64'({24'(2*c + 1), 2'(o), 3'(r), 3'(c)}));
    @(posedge clk); #1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    k = 0; dn = -1;
    while (dn < 0 && k < 5000) begin
      @(posedge clk); #1;
      k++;
      if (s_done) dn = k;
    end
    check("s2_done_time", dn, TO*OH2*OW2*(N+1));
    check("s2_queue_empty", sq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_tile_engine.md
Name: conv_tile_engine

Overview:
- Parametrised sequential convolution engine for one tile of a CNN layer.
- Computes every output pixel of every output channel from a flat input-feature-map tile and a flat weight vector. Uses one signed MAC per cycle.
- Results stream out one pixel at a time under a valid/ready handshake.
- Adds configurable stride, channel counts, kernel size, optional ReLU and output backpressure.

Parameters:
- DW, 8: signed data width of ifm and weight elements.
- TI, 3: input channels.
- TO, 4: output channels.
- IH, 11: input tile height.
- IW, 11: input tile width.
- K, 3: square kernel size.
- S, 1: stride.
- ACC_W, 24: accumulator and output width.
- Derived: OH=(IH-K)/S+1, OW=(IW-K)/S+1, N=TI*K*K.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin tile; sampled only in IDLE.
- relu_en  in  1  ReLU mode; latched on the cycle start is accepted.
- ifm_data  in  TI*IH*IW*DW  element (ti,r,c) at bit ((ti*IH+r)*IW+c)*DW, DW wide.
- wgt_data  in  TO*TI*K*K*DW  element (to,ti,i,j) at bit (((to*TI+ti)*K+i)*K+j)*DW, DW wide.
- busy  out  1  high in MAC and OUT.
- done  out  1  one-cycle pulse at end of tile.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  ACC_W  convolution result.
- out_ch  out  max(1,$clog2(TO))  output channel of result.
- out_row  out  max(1,$clog2(OH))  output row.
- out_col  out  max(1,$clog2(OW))  output column.

Behaviour:
- Reset (asynchronous, any state including mid-tile):
  - State goes to IDLE.
  - All counters and the accumulator clear.
  - busy, done, out_valid, out_data, out_ch, out_row and out_col all read 0.
- FSM states: IDLE, MAC, OUT, DONE.
- IDLE:
  - start=1 at the clock edge: latch relu_en, clear to/row/col/ti/i/j counters and acc, go to MAC.
  - start in any other state is ignored.
- MAC:
  - Each cycle: acc += sext(w(to,ti,i,j)) * sext(x(ti, row*S+i, col*S+j)), signed.
  - Counter order: j fastest, then i, then ti.
  - After exactly N accumulate cycles, go to OUT. On that same edge load:
    - out_data = (relu && final acc<0) ? 0 : final acc.
    - out_ch/out_row/out_col from the current to/row/col counters.
    - out_valid=1.
- Arithmetic: the product is 2*DW signed and sign-extended to ACC_W. The accumulator wraps modulo 2^ACC_W with no saturation. Defaults cannot overflow.
- OUT:
  - out_valid, out_data and indices are held stable until out_valid && out_ready. No MAC activity meanwhile.
  - On handshake: out_valid drops; counters advance col, then row, then to (col fastest).
  - If the pixel just sent was the last (to=TO-1, row=OH-1, col=OW-1), go to DONE. Otherwise clear acc and ti/i/j and go to MAC.
- DONE: done=1 for one cycle, busy=0, then IDLE. A start during DONE is ignored.
- Timing with out_ready held high:
  - out_valid first rises N cycles after the start edge.
  - Each pixel takes N+1 cycles.
  - done asserts the cycle after the last handshake.
  - Total start-to-done = TO*OH*OW*(N+1) cycles.
- Output order: to-major, then row, then col.
- ifm_data and wgt_data must stay stable while busy. The engine does not register them.

Test Plan:
- Defaults, all ifm=1, all weights=1, relu_en=0, out_ready=1 -> 324 results, each 27. Order runs (0,0,0),(0,0,1)..(3,8,8). done pulses once, 324*28 cycles after start.
- All weights=-1, ifm=1 -> with relu_en=0 every out_data=24'hFFFFE5 (-27); rerun with relu_en=1 -> every out_data=0.
- Backpressure: out_ready=0 for 5 cycles on the first result -> out_valid=1, out_data=27, indices (0,0,0) stable for all 5 cycles. Next result appears N cycles after the handshake.
- Stride instance S=2, IH=IW=11, K=3 (OH=OW=5): ifm(ti,r,c)=c, only w(to,0,1,1)=1, rest 0 -> out[to][r][c]=2c+1, i.e. cols give 1,3,5,7,9.
- rst_n pulsed low mid-MAC of pixel (1,4,4) -> all outputs 0 immediately, busy=0. A following start produces the full correct 324-result tile.
- start held high through busy and the DONE cycle -> exactly one tile is run. A new tile begins only from IDLE, and done pulses exactly once per tile.
